// File: rtl/mem_seq_pkg.sv
// Shared definitions for the memory-access sequencer: state encoding, AdAs
// addressing-mode codes, byte-enable codes and the default CALC_done timeout.
package mem_seq_pkg;

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    IDX_S = 4'd1,
    RD_S  = 4'd2,
    IDX_D = 4'd3,
    RD_D  = 4'd4,
    EXEC  = 4'd5,
    WB    = 4'd6,
    DONE  = 4'd7,
    HOLD  = 4'd8
  } seq_state_t;

  localparam logic [2:0] ADAS_SRC_IDX  = 3'b001;
  localparam logic [2:0] ADAS_DST_IDX  = 3'b100;
  localparam logic [2:0] ADAS_BOTH_IDX = 3'b101;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_LO   = 2'b01;

  localparam int CALC_WAIT_MAX_DEF = 4;

endpackage

// File: rtl/mem_seq_byte_lane.sv
// Byte-lane steering for operand accesses: lane extract on read, lane
// replication and byte enables on write. Exists only with BYTE_ACCESS_EN.
`ifdef BYTE_ACCESS_EN
module byte_lane
  import mem_seq_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              bw,
  input  logic              ea_lsb,
  input  logic [DATA_W-1:0] rd_word,
  input  logic [DATA_W-1:0] wr_src,
  output logic [DATA_W-1:0] rd_op,
  output logic [DATA_W-1:0] wr_word,
  output logic [1:0]        be
);

  always_comb begin
    rd_op   = rd_word;
    wr_word = wr_src;
    be      = BE_WORD;
    if (bw) begin
      rd_op      = '0;
      rd_op[7:0] = ea_lsb ? rd_word[15:8] : rd_word[7:0];
      wr_word    = {(DATA_W/8){wr_src[7:0]}};
      be         = ea_lsb ? BE_HI : BE_LO;
    end
  end

endmodule
`endif

// File: rtl/mem_seq.sv
// Memory-access sequencer between execute control and the memory bus: fetches index
// words for calc, reads indexed operands, writes results back. Byte access: BYTE_ACCESS_EN.
//
// state | meaning
// IDLE  | waiting for MC, latches addressing mode
// IDX_S | fetching source index word until CALC_done
// RD_S  | reading source operand at ea_s
// IDX_D | fetching destination index word until CALC_done
// RD_D  | reading destination operand at ea_d
// EXEC  | operands valid, waiting for res_valid
// WB    | single-cycle write of result to ea_d
// DONE  | SEQ_done pulse
// HOLD  | parked until MC drops
module mem_seq
  import mem_seq_pkg::*;
#(
  parameter int ADDR_W        = 16,
  parameter int DATA_W        = 16,
  parameter int CALC_WAIT_MAX = CALC_WAIT_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MC,
  input  logic [2:0]        AdAs,
  input  logic              wr_dst,
  input  logic              BW,
  input  logic [ADDR_W-1:0] PC,
  input  logic [ADDR_W-1:0] CALC_out,
  input  logic              CALC_done,
  input  logic [DATA_W-1:0] MDB_out,
  input  logic [DATA_W-1:0] result,
  input  logic              res_valid,
  output logic [ADDR_W-1:0] MAB,
  output logic [DATA_W-1:0] MDB_in,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [1:0]        mem_be,
  output logic              pc_inc,
  output logic [DATA_W-1:0] src_op,
  output logic [DATA_W-1:0] dst_op,
  output logic              ops_valid,
  output logic              SEQ_done,
  output logic              seq_err
);

  localparam int CNT_W = $clog2(CALC_WAIT_MAX + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(CALC_WAIT_MAX - 1);

  seq_state_t        state;
  logic              ad_q;
  logic              wr_q;
  logic              bw_q;
  logic [ADDR_W-1:0] ea_s;
  logic [ADDR_W-1:0] ea_d;
  logic [ADDR_W-1:0] ea_cur;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] res_q;
  logic [DATA_W-1:0] rd_op;
  logic [DATA_W-1:0] wr_word;
  logic [1:0]        lane_be;
  logic [CNT_W-1:0]  wait_cnt;

  assign ea_cur = (state == RD_S) ? ea_s : ea_d;

`ifdef BYTE_ACCESS_EN
  byte_lane #(.DATA_W(DATA_W)) u_byte_lane (
    .bw      (bw_q),
    .ea_lsb  (ea_cur[0]),
    .rd_word (MDB_out),
    .wr_src  (res_q),
    .rd_op   (rd_op),
    .wr_word (wr_word),
    .be      (lane_be)
  );
  assign op_addr = bw_q ? ea_cur : {ea_cur[ADDR_W-1:1], 1'b0};
`else
  logic unused_byte_bits;
  assign unused_byte_bits = ^{bw_q, ea_cur[0]};
  assign rd_op   = MDB_out;
  assign wr_word = res_q;
  assign lane_be = BE_WORD;
  assign op_addr = {ea_cur[ADDR_W-1:1], 1'b0};
`endif

  // Bus is decoded from registered state so MDB_out settles within the same cycle.
  always_comb begin
    MAB    = '0;
    MDB_in = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    mem_be = 2'b00;
    case (state)
      IDX_S, IDX_D: begin
        MAB    = PC;
        mem_rd = 1'b1;
        mem_be = BE_WORD;
      end
      RD_S, RD_D: begin
        MAB    = op_addr;
        mem_rd = 1'b1;
        mem_be = lane_be;
      end
      WB: begin
        MAB    = op_addr;
        MDB_in = wr_word;
        mem_wr = 1'b1;
        mem_be = lane_be;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ad_q      <= 1'b0;
      wr_q      <= 1'b0;
      bw_q      <= 1'b0;
      ea_s      <= '0;
      ea_d      <= '0;
      res_q     <= '0;
      wait_cnt  <= '0;
      src_op    <= '0;
      dst_op    <= '0;
      pc_inc    <= 1'b0;
      ops_valid <= 1'b0;
      SEQ_done  <= 1'b0;
      seq_err   <= 1'b0;
    end else begin
      pc_inc    <= 1'b0;
      ops_valid <= 1'b0;
      SEQ_done  <= 1'b0;
      seq_err   <= 1'b0;
      if (!MC) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            ad_q     <= AdAs[2];
            wr_q     <= wr_dst;
            bw_q     <= BW;
            wait_cnt <= WAIT_LOAD;
            if (AdAs[1:0] == ADAS_SRC_IDX[1:0]) begin
              state <= IDX_S;
            end else if ((AdAs & ADAS_DST_IDX) != 3'b000) begin
              state <= IDX_D;
            end else begin
              state    <= DONE;
              SEQ_done <= 1'b1;
            end
          end
          IDX_S, IDX_D: begin
            if (CALC_done) begin
              pc_inc   <= 1'b1;
              wait_cnt <= WAIT_LOAD;
              if (state == IDX_S) begin
                ea_s  <= CALC_out;
                state <= RD_S;
              end else begin
                ea_d  <= CALC_out;
                state <= RD_D;
              end
            end else if (wait_cnt == '0) begin
              seq_err <= 1'b1;
              state   <= HOLD;
            end else begin
              wait_cnt <= wait_cnt - 1'b1;
            end
          end
          RD_S: begin
            src_op <= rd_op;
            if (ad_q) begin
              state <= IDX_D;
            end else begin
              state     <= EXEC;
              ops_valid <= 1'b1;
            end
          end
          RD_D: begin
            dst_op    <= rd_op;
            state     <= EXEC;
            ops_valid <= 1'b1;
          end
          EXEC: begin
            if (res_valid) begin
              res_q <= result;
              if (wr_q && ad_q) begin
                state <= WB;
              end else begin
                state    <= DONE;
                SEQ_done <= 1'b1;
              end
            end
          end
          WB: begin
            state    <= DONE;
            SEQ_done <= 1'b1;
          end
          DONE:    state <= HOLD;
          HOLD:    state <= HOLD;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_seq.sv
// Self-checking bench for mem_seq: directed scenarios plus randomized transactions
// checked against a transaction-level model of indexed operand access.
`timescale 1ns/1ps
module tb_mem_seq;
  import mem_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst, MC, wr_dst, BW, CALC_done, res_valid;
  logic [2:0]  AdAs;
  logic [15:0] PC, CALC_out, MDB_out, result;
  logic [15:0] MAB, MDB_in, src_op, dst_op;
  logic        mem_rd, mem_wr, pc_inc, ops_valid, SEQ_done, seq_err;
  logic [1:0]  mem_be;

  logic [15:0] mem [0:32767];

  int vectors = 0;
  int miscompares = 0;
  int n_pc = 0, n_wr = 0, n_rd = 0, n_done = 0, n_ops = 0, n_err = 0, n_bad = 0;
  int b_pc, b_wr, b_rd, b_done, b_ops, b_err, b_bad;
  logic [15:0] wr_addr = '0, wr_data = '0;
  logic [1:0]  wr_be = '0;
  logic [15:0] exp_src, exp_dst;

  always #5 clk = ~clk;

  assign MDB_out = mem[MAB[15:1]];

  mem_seq #(.ADDR_W(16), .DATA_W(16), .CALC_WAIT_MAX(4)) dut (
    .clk(clk), .rst(rst), .MC(MC), .AdAs(AdAs), .wr_dst(wr_dst), .BW(BW), .PC(PC),
    .CALC_out(CALC_out), .CALC_done(CALC_done), .MDB_out(MDB_out), .result(result),
    .res_valid(res_valid), .MAB(MAB), .MDB_in(MDB_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_be(mem_be), .pc_inc(pc_inc), .src_op(src_op), .dst_op(dst_op),
    .ops_valid(ops_valid), .SEQ_done(SEQ_done), .seq_err(seq_err)
  );

  // Bus monitor: counts strobes/pulses and records the last write.
  always @(negedge clk) begin
    if (pc_inc) n_pc++;
    if (mem_rd) n_rd++;
    if (mem_wr) begin
      n_wr++;
      wr_addr = MAB;
      wr_data = MDB_in;
      wr_be   = mem_be;
    end
    if (SEQ_done) n_done++;
    if (ops_valid) n_ops++;
    if (seq_err) n_err++;
    if (!mem_rd && !mem_wr && (MAB != 16'h0 || MDB_in != 16'h0 || mem_be != 2'b00)) n_bad++;
  end

  task automatic snap();
    b_pc = n_pc; b_wr = n_wr; b_rd = n_rd; b_done = n_done;
    b_ops = n_ops; b_err = n_err; b_bad = n_bad;
  endtask

  // Plays calc for one index word: waits for the fetch, then pulses CALC_done in cycle d.
  task automatic calc_word(input logic [15:0] ea, input int d, output logic [15:0] idx, output bit to);
    to  = 1'b0;
    idx = '0;
    for (int i = 0; i < 20 && !(mem_rd && MAB == PC); i++) @(negedge clk);
    if (!(mem_rd && MAB == PC)) begin
      to = 1'b1;
      return;
    end
    idx = MDB_out;
    repeat (d - 1) @(negedge clk);
    CALC_out  = ea;
    CALC_done = 1'b1;
    @(negedge clk);
    CALC_done = 1'b0;
    if (pc_inc) PC = PC + 16'd2;
  endtask

  task automatic drive_txn(input logic [2:0] adas, input logic wr, input logic bw,
                           input logic [15:0] eas, input logic [15:0] ead, input logic [15:0] res,
                           input int ds, input int dd, input int dr,
                           output logic [15:0] idx, output bit to);
    bit t1, t2;
    logic [15:0] i2;
    t1 = 1'b0; t2 = 1'b0; idx = '0;
    @(negedge clk);
    AdAs = adas; wr_dst = wr; BW = bw; MC = 1'b1;
    if (adas[1:0] == 2'b01) calc_word(eas, ds, idx, t1);
    if (adas[2] && !t1) calc_word(ead, dd, i2, t2);
    if ((adas[1:0] == 2'b01 || adas[2]) && !t1 && !t2) begin
      for (int i = 0; i < 10 && !ops_valid; i++) @(negedge clk);
      if (!ops_valid) t2 = 1'b1;
      else begin
        repeat (dr) @(negedge clk);
        result = res; res_valid = 1'b1;
        @(negedge clk);
        res_valid = 1'b0;
      end
    end
    for (int i = 0; i < 12 && !SEQ_done; i++) @(negedge clk);
    to = t1 | t2 | !SEQ_done;
    repeat (2) @(negedge clk);
    MC = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; MC = 1'b0; AdAs = 3'b000; wr_dst = 1'b0; BW = 1'b0; PC = '0;
    CALC_done = 1'b0; CALC_out = '0; res_valid = 1'b0; result = '0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({MAB, MDB_in, mem_rd, mem_wr, mem_be, pc_inc, src_op, dst_op, ops_valid, SEQ_done, seq_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: MAB=%h MDB_in=%h rd=%b wr=%b be=%b src=%h dst=%h, want all 0",
               MAB, MDB_in, mem_rd, mem_wr, mem_be, src_op, dst_op);
    end
    rst = 1'b0; exp_src = '0; exp_dst = '0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({mem_rd, mem_wr, SEQ_done} !== 3'b000) begin
      miscompares++;
      $display("FAIL idle_quiet: rd=%b wr=%b done=%b, want 000", mem_rd, mem_wr, SEQ_done);
    end
  endtask

  task automatic test_src_idx();
    logic [15:0] idx; bit to;
    PC = 16'h0100; mem[15'h0080] = 16'h0004; mem[15'h0102] = 16'hBEEF;
    snap();
    drive_txn(ADAS_SRC_IDX, 1'b0, 1'b0, 16'h0204, 16'h0000, 16'h5555, 2, 1, 1, idx, to);
    exp_src = 16'hBEEF;
    vectors++;
    if (to || idx !== 16'h0004) begin
      miscompares++; $display("FAIL src_idx_word: timeout=%b MDB_out=%h, want 0/0004", to, idx);
    end
    vectors++;
    if (src_op !== exp_src || dst_op !== exp_dst) begin
      miscompares++; $display("FAIL src_idx_ops: src=%h dst=%h, want %h %h", src_op, dst_op, exp_src, exp_dst);
    end
    vectors++;
    if (n_pc - b_pc != 1 || n_ops - b_ops != 1 || n_done - b_done != 1 || n_wr - b_wr != 0 || n_rd - b_rd != 3) begin
      miscompares++;
      $display("FAIL src_idx_pulses: pc_inc=%0d ops=%0d done=%0d wr=%0d rd=%0d, want 1 1 1 0 3",
               n_pc - b_pc, n_ops - b_ops, n_done - b_done, n_wr - b_wr, n_rd - b_rd);
    end
  endtask

  task automatic test_both_wb();
    logic [15:0] idx; bit to;
    PC = 16'h0180; mem[15'h00C0] = 16'h0010; mem[15'h00C1] = 16'h0020;
    mem[15'h0188] = 16'h1111; mem[15'h0191] = 16'h2222;
    snap();
    drive_txn(ADAS_BOTH_IDX, 1'b1, 1'b0, 16'h0310, 16'h0322, 16'h1234, 1, 2, 2, idx, to);
    exp_src = 16'h1111; exp_dst = 16'h2222;
    vectors++;
    if (to || src_op !== exp_src || dst_op !== exp_dst) begin
      miscompares++; $display("FAIL both_ops: to=%b src=%h dst=%h, want 0 %h %h", to, src_op, dst_op, exp_src, exp_dst);
    end
    vectors++;
    if (n_wr - b_wr != 1 || wr_addr !== 16'h0322 || wr_data !== 16'h1234 || wr_be !== 2'b11) begin
      miscompares++;
      $display("FAIL both_wb: writes=%0d addr=%h data=%h be=%b, want 1 0322 1234 11",
               n_wr - b_wr, wr_addr, wr_data, wr_be);
    end
    vectors++;
    if (n_pc - b_pc != 2 || n_done - b_done != 1 || n_bad != b_bad) begin
      miscompares++;
      $display("FAIL both_pulses: pc_inc=%0d done=%0d idle_bus_err=%0d, want 2 1 0",
               n_pc - b_pc, n_done - b_done, n_bad - b_bad);
    end
  endtask

  task automatic test_abort();
    logic [15:0] idx; bit to;
    PC = 16'h01A0; mem[15'h00D0] = 16'h0001; mem[15'h00D1] = 16'h0002;
    mem[15'h0280] = 16'h3C3C; mem[15'h0290] = 16'h9999;
    snap();
    @(negedge clk);
    AdAs = ADAS_BOTH_IDX; wr_dst = 1'b1; MC = 1'b1;
    calc_word(16'h0500, 1, idx, to);
    exp_src = 16'h3C3C;
    for (int i = 0; i < 10 && !(mem_rd && MAB == PC); i++) @(negedge clk);
    MC = 1'b0;
    @(negedge clk);
    vectors++;
    if (to || mem_rd !== 1'b0 || mem_wr !== 1'b0 || MAB !== 16'h0) begin
      miscompares++; $display("FAIL abort_idle: to=%b rd=%b wr=%b MAB=%h, want 0 0 0 0000", to, mem_rd, mem_wr, MAB);
    end
    repeat (3) @(negedge clk);
    #1;
    vectors++;
    if (n_done != b_done || n_wr != b_wr || src_op !== exp_src || dst_op !== exp_dst) begin
      miscompares++;
      $display("FAIL abort_effects: done=%0d wr=%0d src=%h dst=%h, want 0 0 %h %h",
               n_done - b_done, n_wr - b_wr, src_op, dst_op, exp_src, exp_dst);
    end
    PC = 16'h01B0; mem[15'h00D8] = 16'h0003; mem[15'h0320] = 16'h4242;
    snap();
    drive_txn(ADAS_SRC_IDX, 1'b0, 1'b0, 16'h0640, 16'h0000, 16'h0, 1, 1, 0, idx, to);
    exp_src = 16'h4242;
    vectors++;
    if (to || n_done - b_done != 1 || src_op !== exp_src) begin
      miscompares++; $display("FAIL abort_restart: to=%b done=%0d src=%h, want 0 1 %h", to, n_done - b_done, src_op, exp_src);
    end
  endtask

  task automatic test_timeout();
    logic [15:0] idx; bit to;
    PC = 16'h01C0; mem[15'h00E0] = 16'h0007; mem[15'h0400] = 16'h7E57;
    snap();
    drive_txn(ADAS_SRC_IDX, 1'b0, 1'b0, 16'h0800, 16'h0, 16'h0, 4, 1, 0, idx, to);
    exp_src = 16'h7E57;
    vectors++;
    if (to || n_err != b_err || n_done - b_done != 1 || src_op !== exp_src) begin
      miscompares++;
      $display("FAIL timeout_edge: to=%b err=%0d done=%0d src=%h, want 0 0 1 %h", to, n_err - b_err, n_done - b_done, src_op, exp_src);
    end
    snap();
    @(negedge clk);
    AdAs = ADAS_SRC_IDX; MC = 1'b1;
    repeat (10) @(negedge clk);
    #1;
    vectors++;
    if (n_err - b_err != 1 || n_rd - b_rd != 4 || n_done != b_done || src_op !== exp_src || mem_rd !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_err: err=%0d rd=%0d done=%0d src=%h rd_now=%b, want 1 4 0 %h 0",
               n_err - b_err, n_rd - b_rd, n_done - b_done, src_op, mem_rd, exp_src);
    end
    MC = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_wb();
    logic [15:0] idx; bit to, t2;
    PC = 16'h01D0; mem[15'h00E8] = 16'h0011; mem[15'h00E9] = 16'h0022;
    @(negedge clk);
    AdAs = ADAS_BOTH_IDX; wr_dst = 1'b1; MC = 1'b1;
    calc_word(16'h0A00, 1, idx, to);
    calc_word(16'h0A10, 2, idx, t2);
    for (int i = 0; i < 10 && !ops_valid; i++) @(negedge clk);
    result = 16'hCAFE; res_valid = 1'b1;
    @(negedge clk);
    res_valid = 1'b0;
    for (int i = 0; i < 6 && !mem_wr; i++) @(negedge clk);
    vectors++;
    if (to || t2 || mem_wr !== 1'b1) begin
      miscompares++; $display("FAIL reset_wb_reach: to=%b%b mem_wr=%b, want 00 1", to, t2, mem_wr);
    end
    rst = 1'b1; MC = 1'b0;
    @(negedge clk);
    vectors++;
    if ({MAB, MDB_in, mem_rd, mem_wr, mem_be, pc_inc, src_op, dst_op, ops_valid, SEQ_done, seq_err} !== '0) begin
      miscompares++;
      $display("FAIL reset_wb_outputs: MAB=%h MDB_in=%h rd=%b wr=%b be=%b src=%h dst=%h, want all 0",
               MAB, MDB_in, mem_rd, mem_wr, mem_be, src_op, dst_op);
    end
    rst = 1'b0; exp_src = '0; exp_dst = '0;
    snap();
    drive_txn(3'b000, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0, 1, 1, 0, idx, to);
    vectors++;
    if (to || n_done - b_done != 1 || n_rd != b_rd || n_wr != b_wr || n_ops != b_ops || n_pc != b_pc) begin
      miscompares++;
      $display("FAIL no_index: to=%b done=%0d rd=%0d wr=%0d ops=%0d pc_inc=%0d, want 0 1 0 0 0 0",
               to, n_done - b_done, n_rd - b_rd, n_wr - b_wr, n_ops - b_ops, n_pc - b_pc);
    end
  endtask

`ifdef BYTE_ACCESS_EN
  task automatic test_byte();
    logic [15:0] idx; bit to;
    PC = 16'h01E0; mem[15'h00F0] = 16'h0001; mem[15'h00F1] = 16'h0002; mem[15'h0102] = 16'hAB12;
    snap();
    drive_txn(ADAS_BOTH_IDX, 1'b1, 1'b1, 16'h0205, 16'h0205, 16'h0077, 1, 2, 0, idx, to);
    exp_src = 16'h00AB; exp_dst = 16'h00AB;
    vectors++;
    if (to || src_op !== exp_src || dst_op !== exp_dst) begin
      miscompares++; $display("FAIL byte_read: to=%b src=%h dst=%h, want 0 00AB 00AB", to, src_op, dst_op);
    end
    vectors++;
    if (n_wr - b_wr != 1 || wr_addr !== 16'h0205 || wr_data !== 16'h7777 || wr_be !== 2'b10) begin
      miscompares++;
      $display("FAIL byte_write: writes=%0d addr=%h data=%h be=%b, want 1 0205 7777 10",
               n_wr - b_wr, wr_addr, wr_data, wr_be);
    end
  endtask
`endif

  task automatic test_random();
    logic [15:0] idx, eas, ead, res;
    logic [2:0] adas;
    logic wr;
    bit to, s, d;
    int ds, dd, dr, exp_rd, exp_wr;
    for (int t = 0; t < 24; t++) begin
      adas = 3'($urandom_range(0, 7));
      wr   = 1'($urandom_range(0, 1));
      s    = (adas[1:0] == 2'b01);
      d    = adas[2];
      PC   = 16'h0100 + 16'($urandom_range(0, 60)) * 16'd2;
      mem[PC[15:1]] = 16'($urandom);
      mem[PC[15:1] + 15'd1] = 16'($urandom);
      eas = 16'h0400 + 16'($urandom_range(0, 16'h3000));
      ead = 16'h0400 + 16'($urandom_range(0, 16'h3000));
      mem[eas[15:1]] = 16'($urandom);
      mem[ead[15:1]] = 16'($urandom);
      ds  = $urandom_range(1, 4);
      dd  = $urandom_range(1, 4);
      dr  = $urandom_range(0, 3);
      res = 16'($urandom);
      if (s) exp_src = mem[eas[15:1]];
      if (d) exp_dst = mem[ead[15:1]];
      exp_rd = (s ? ds + 1 : 0) + (d ? dd + 1 : 0);
      exp_wr = (d && wr) ? 1 : 0;
      snap();
      drive_txn(adas, wr, 1'b0, eas, ead, res, ds, dd, dr, idx, to);
      vectors++;
      if (to || src_op !== exp_src || dst_op !== exp_dst) begin
        miscompares++;
        $display("FAIL rand_ops[%0d] AdAs=%b: to=%b src=%h dst=%h, want 0 %h %h", t, adas, to, src_op, dst_op, exp_src, exp_dst);
      end
      vectors++;
      if (n_pc - b_pc != int'(s) + int'(d) || n_rd - b_rd != exp_rd || n_ops - b_ops != int'(s | d) ||
          n_done - b_done != 1 || n_err != b_err || n_bad != b_bad) begin
        miscompares++;
        $display("FAIL rand_pulses[%0d] AdAs=%b: pc_inc=%0d rd=%0d ops=%0d done=%0d err=%0d bus=%0d, want %0d %0d %0d 1 0 0",
                 t, adas, n_pc - b_pc, n_rd - b_rd, n_ops - b_ops, n_done - b_done, n_err - b_err,
                 n_bad - b_bad, int'(s) + int'(d), exp_rd, int'(s | d));
      end
      vectors++;
      if (n_wr - b_wr != exp_wr || (exp_wr == 1 && (wr_addr !== {ead[15:1], 1'b0} || wr_data !== res || wr_be !== 2'b11))) begin
        miscompares++;
        $display("FAIL rand_wb[%0d] AdAs=%b wr=%b: writes=%0d addr=%h data=%h be=%b, want %0d %h %h 11",
                 t, adas, wr, n_wr - b_wr, wr_addr, wr_data, wr_be, exp_wr, {ead[15:1], 1'b0}, res);
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_src_idx();
    test_both_wb();
    test_abort();
    test_timeout();
`ifdef BYTE_ACCESS_EN
    test_byte();
`endif
    test_random();
    test_reset_mid_wb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
